// File: rtl/result_display.sv
// Holds the latest ALU result and scans one 16-bit page of it in hex onto a
// 4-digit multiplexed seven-segment display, with sticky exception flags.
module result_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] result_in,
    input  logic [4:0]  flags_in,
    input  logic        mode_fp,
    input  logic        show_hi,
    input  logic        flag_clr,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [4:0]  flags_sticky,
    output logic        captured
);

    localparam int unsigned PRESC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned RESULT_W = 32;
    localparam int unsigned FLAGS_W  = 5;
    localparam int unsigned PAGE_W   = 16;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned DIGITS   = 4;

    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

    logic [RESULT_W-1:0] held_q,   held_d;
    logic [FLAGS_W-1:0]  flags_q,  flags_d;
    logic                cap_q,    cap_d;
    logic [PRESC_W-1:0]  presc_q,  presc_d;
    logic [1:0]          idx_q,    idx_d;
    logic [SEG_W-1:0]    seg_q,    seg_d;
    logic                dp_q,     dp_d;
    logic [DIGITS-1:0]   an_q,     an_d;

    logic [PAGE_W-1:0]   word;
    logic [3:0]          nibble;
    logic                hi_page;
    logic                blank;

    // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] n);
        logic [SEG_W-1:0] s;
        s = SEG_OFF;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Result capture and sticky flags; a same-cycle clear keeps the new flags.
    always_comb begin
        held_d  = held_q;
        flags_d = flags_q;
        cap_d   = cap_q;
        if (valid_in) begin
            held_d  = result_in;
            cap_d   = 1'b1;
            flags_d = flag_clr ? flags_in : (flags_q | flags_in);
        end else if (flag_clr) begin
            flags_d = '0;
        end
    end

    // Digit scan: prescaler wraps at REFRESH_DIV-1 and advances the digit.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    assign hi_page = mode_fp & show_hi;
    assign word    = hi_page ? held_q[31:16] : held_q[15:0];
    assign nibble  = word[{idx_q, 2'b00} +: 4];
    assign blank   = (presc_q < PRESC_W'(BLANK_CYC));

    // Display drive, registered one cycle behind the scan position.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = cap_q ? hex_to_seg(nibble) : SEG_DASH;
            if ((idx_q == 2'd3) && hi_page) begin
                dp_d = 1'b0;
            end else if ((idx_q == 2'd0) && (flags_q != '0)) begin
                dp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= '0;
            flags_q <= '0;
            cap_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            held_q  <= held_d;
            flags_q <= flags_d;
            cap_q   <= cap_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign flags_sticky = flags_q;
    assign captured     = cap_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with a short scan period (8 cycles, 2 blank).
module tb_result_display;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] result_in;
    logic [4:0]  flags_in;
    logic        mode_fp;
    logic        show_hi;
    logic        flag_clr;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [4:0]  flags_sticky;
    logic        captured;

    int n_cmp;
    int n_err;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] SB    = 7'b0000011;
    localparam logic [6:0] SC    = 7'b1000110;
    localparam logic [6:0] SD    = 7'b0100001;
    localparam logic [6:0] SF    = 7'b0001110;
    localparam logic [6:0] SDASH = 7'b0111111;

    result_display #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .result_in    (result_in),
        .flags_in     (flags_in),
        .mode_fp      (mode_fp),
        .show_hi      (show_hi),
        .flag_clr     (flag_clr),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .flags_sticky (flags_sticky),
        .captured     (captured)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) at negedges until the given anode pattern is driven.
    task automatic wait_an(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (an !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(an), 32'(target));
    endtask

    task automatic check_page(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
        logic [6:0] exp_seg [4];
        logic [3:0] sel;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        for (int i = 0; i < 4; i++) begin
            sel = 4'(4'b0001 << i);
            wait_an($sformatf("%s_an%0d", tag, i), ~sel);
            chk($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp_seg[i]));
            chk($sformatf("%s_dp%0d", tag, i), 32'(dp), 32'(dpn[i]));
        end
    endtask

    task automatic capture(input logic [31:0] r, input logic [4:0] f, input logic clr);
        result_in = r;
        flags_in  = f;
        flag_clr  = clr;
        valid_in  = 1'b1;
        @(negedge clk);
        valid_in  = 1'b0;
        flag_clr  = 1'b0;
        flags_in  = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_an;
        logic [3:0] sel;
        int n;
        n_cmp     = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        valid_in  = 1'b0;
        result_in = '0;
        flags_in  = '0;
        mode_fp   = 1'b0;
        show_hi   = 1'b0;
        flag_clr  = 1'b0;

        // 1. reset values, then dashes before any capture
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_captured", 32'(captured), 32'h0);
        chk("rst_flags", 32'(flags_sticky), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_page("dash", SDASH, SDASH, SDASH, SDASH, 4'b1111);
        chk("dash_captured", 32'(captured), 32'h0);
        chk("dash_flags", 32'(flags_sticky), 32'h0);

        // 2. single precision, low then high page
        mode_fp = 1'b1;
        show_hi = 1'b0;
        capture(32'h40490FDB, 5'b00000, 1'b0);
        chk("cap_captured", 32'(captured), 32'h1);
        check_page("sp_lo", SB, SD, SF, S0, 4'b1111);
        show_hi = 1'b1;
        repeat (2) @(negedge clk);
        check_page("sp_hi", S9, S4, S0, S4, 4'b0111);

        // 3. half mode ignores show_hi
        mode_fp = 1'b0;
        capture(32'h12343C00, 5'b00000, 1'b0);
        check_page("hp", S0, S0, SC, S3, 4'b1111);

        // 4. sticky flags, clear-with-capture, plain clear
        capture(32'h00000005, 5'b00100, 1'b0);
        capture(32'h00000005, 5'b00000, 1'b0);
        chk("sticky_or", 32'(flags_sticky), 32'h04);
        check_page("flag_dp", S5, S0, S0, S0, 4'b1110);
        capture(32'h00000005, 5'b00010, 1'b1);
        chk("clr_with_cap", 32'(flags_sticky), 32'h02);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("clr_alone", 32'(flags_sticky), 32'h00);
        repeat (2) @(negedge clk);
        check_page("noflag_dp", S5, S0, S0, S0, 4'b1111);

        // 5. scan timing from the first active cycle of digit 0
        wait_an("sync_blank", 4'b1111);
        wait_an("sync_d0", 4'b1110);
        for (int k = 0; k < 40; k++) begin
            sel    = 4'(4'b0001 << ((k / 8) % 4));
            exp_an = ((k % 8) < 6) ? ~sel : 4'b1111;
            chk($sformatf("scan_%0d", k), 32'(an), 32'(exp_an));
            @(negedge clk);
        end

        // 6. asynchronous reset during digit 2's active window
        capture(32'h0000ABCD, 5'b10001, 1'b0);
        chk("pre_rst_flags", 32'(flags_sticky), 32'h11);
        wait_an("pre_rst_d2", 4'b1011);
        #1 rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        chk("arst_flags", 32'(flags_sticky), 32'h0);
        chk("arst_captured", 32'(captured), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (an === 4'b1111 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("restart_d0", 32'(an), 32'hE);
        check_page("post_rst", SDASH, SDASH, SDASH, SDASH, 4'b1111);
        chk("post_rst_flags", 32'(flags_sticky), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream consumer of the floating-point ALU's result path on the board top.
- Captures `result`/`flags` on each ALU `valid_out` pulse and holds them until the next capture.
- Drives the 4-digit multiplexed seven-segment display with one 16-bit page of the held result in hex.
- Keeps a sticky copy of the exception flags for the board LEDs.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is scanned (1 kHz per digit at 100 MHz); legal when REFRESH_DIV >= BLANK_CYC+2.
- BLANK_CYC, 4, cycles at the start of each digit slot with all anodes off (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- valid_in  input  1  capture strobe (ALU valid_out), one-cycle pulse
- result_in  input  32  ALU result
- flags_in  input  5  ALU exception flags
- mode_fp  input  1  0=half (16-bit result in [15:0]), 1=single
- show_hi  input  1  page select: 1 shows held[31:16] (single mode only)
- flag_clr  input  1  clears sticky flags
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low, an[0] = rightmost digit
- flags_sticky  output  5  OR-accumulated flags since last clear
- captured  output  1  high once any result has been captured since reset

Behaviour:
Reset (asynchronous, active-high):
- held result = 0; flags_sticky = 0; captured = 0.
- Digit index = 0; prescaler = 0.
- an = 4'b1111, seg = 7'b1111111, dp = 1.
- All outputs are registered.

Capture:
- On a rising edge with valid_in=1: held <= result_in; flags_sticky <= flags_sticky | flags_in; captured <= 1.
- flag_clr=1 alone: flags_sticky <= 0.
- flag_clr and valid_in in the same cycle: flags_sticky <= flags_in (new flags win).

Page select:
- word = (mode_fp & show_hi) ? held[31:16] : held[15:0].
- In half mode the low page is always shown.

Scan:
- Prescaler counts 0..REFRESH_DIV-1.
- At the terminal count the prescaler wraps to 0 and the digit index increments mod 4 (3 wraps to 0).
- Digit i shows nibble word[4i+3:4i].
- While prescaler < BLANK_CYC: an = 1111. Otherwise an[i] = 0 for the current index only.
- Outputs are registered, one cycle after prescaler/index: the first cycle of slot i shows an = 1111, then digit i is active for REFRESH_DIV-BLANK_CYC cycles.
- Changes to show_hi, mode_fp or held are visible at the next registered update, with no wait for a scan boundary.

Hex encoding (seg, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Before the first capture (captured=0):
- Every digit shows a dash, seg = 0111111.
- Scanning runs normally.

Decimal points:
- Digit 3: dp=0 when the high page is shown (mode_fp & show_hi).
- Digit 0: dp=0 when flags_sticky != 0.
- Otherwise dp=1.

Reset mid-operation:
- All state and outputs return to reset values immediately.
- Scanning restarts at digit 0 after release.

Test Plan:
Run with REFRESH_DIV=8, BLANK_CYC=2.
1. Reset, then release with no capture -> an=1111, seg=1111111, dp=1 during reset. After release, each digit shows seg=0111111, captured=0, flags_sticky=0.
2. valid_in with result_in=0x40490FDB, mode_fp=1, show_hi=0 -> digits 0..3 show seg 0000011 (b), 0100001 (d), 0001110 (F), 1000000 (0); captured=1. Set show_hi=1 -> digits show 9,4,0,4 (0010000, 0011001, 1000000, 0011001) with dp=0 on digit 3 only.
3. mode_fp=0, show_hi=1, capture 0x12343C00 -> digits show 0,0,C,3 (low page), dp=1 on digit 3.
4. Capture with flags_in=5'b00100, then capture with flags_in=0 -> flags_sticky=00100 and dp=0 on digit 0. Then flag_clr=1 with valid_in=1 and flags_in=00010 in the same cycle -> flags_sticky=00010.
5. Scan timing over 40 cycles -> per slot: an=1111 for 2 cycles, then 1110, 1101, 1011, 0111 in turn, each for 6 cycles. Sequence wraps back to 1110.
6. Assert rst during digit 2's active window -> an/seg/dp go to reset values in the same cycle with no clock edge needed. After release: dashes, scan starts at digit 0, flags_sticky=0.
